// File: rtl/ctrl_pkg.sv
// ctrl_pkg: definitions shared by the fan speed controller and its display block.
//   - FSM state encoding (IDLE / ACCUM / EVAL)
//   - default excess-per-level and downward hysteresis constants
//   - clog2 helper, usable in parameter defaults
package ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_EVAL  = 2'd2;

  localparam int DEFAULT_STEP = 20;
  localparam int DEFAULT_HYST = 2;

  // Smallest r with 2**r >= value; constant-evaluable for parameter defaults.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fan_speed_ctrl_if.sv
// fan_speed_ctrl_if: sample/setpoint inputs and speed outputs of the fan controller.
//   enable      controller enable, low forces the fan off
//   adc_valid   adc carries a valid sample this cycle
//   adc         temperature sample, unsigned, W bits
//   teclado     keypad setpoint, unsigned, W bits
//   giro        current speed level, LW bits
//   giro_chg    one-cycle pulse whenever giro changes
//   diferencia  last evaluated saturating excess over the setpoint
// The master modport is the sampling front end / motor driver side,
// the slave modport is the controller itself.
interface fan_speed_ctrl_if #(
  parameter int W  = 8,
  parameter int LW = 2
);

  logic          enable;
  logic          adc_valid;
  logic [W-1:0]  adc;
  logic [W-1:0]  teclado;
  logic [LW-1:0] giro;
  logic          giro_chg;
  logic [W-1:0]  diferencia;

  modport master (
    output enable, adc_valid, adc, teclado,
    input  giro, giro_chg, diferencia
  );

  modport slave (
    input  enable, adc_valid, adc, teclado,
    output giro, giro_chg, diferencia
  );

endinterface

// File: rtl/sample_avg.sv
// sample_avg: accumulates a window of 2**AVG_LOG2 samples and presents the
// truncated average.
//   clk, rst_n  clock and asynchronous active-low reset
//   clear       synchronous flush of the window (controller disabled)
//   restart     start a new window this cycle, seeded with sample if accepted
//   accept      sample is valid and taken this cycle
//   sample      W-bit unsigned input sample
//   avg         sum >> AVG_LOG2 of the current window
//   done        the last sample of a window is being accepted this cycle
module sample_avg #(
  parameter int W        = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         restart,
  input  logic         accept,
  input  logic [W-1:0] sample,
  output logic [W-1:0] avg,
  output logic         done
);

  localparam int SW = W + AVG_LOG2;
  localparam logic [AVG_LOG2:0] LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

  logic [SW-1:0]     sum;
  logic [AVG_LOG2:0] cnt;

  // The extra counter bit keeps the width legal even for a one-sample window.
  assign done = accept && !restart && (cnt == LAST);
  assign avg  = sum[SW-1:AVG_LOG2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      cnt <= '0;
    end else if (clear) begin
      sum <= '0;
      cnt <= '0;
    end else if (restart) begin
      // A sample arriving during evaluation belongs to the next window.
      sum <= accept ? SW'(sample) : '0;
      cnt <= accept ? (AVG_LOG2 + 1)'(1) : '0;
    end else if (accept) begin
      sum <= sum + SW'(sample);
      cnt <= done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fan_speed_ctrl.sv
// fan_speed_ctrl: averages ADC temperature windows, computes the saturating
// excess over the keypad setpoint and steps the fan speed level one level at
// a time, with downward hysteresis and a minimum dwell between changes.
//   clk    system clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    fan_speed_ctrl_if slave: enable, adc_valid, adc, teclado in;
//          giro, giro_chg, diferencia out
module fan_speed_ctrl
  import ctrl_pkg::*;
#(
  parameter int W        = 8,
  parameter int LEVELS   = 4,
  parameter int LW       = clog2(LEVELS),
  parameter int STEP     = DEFAULT_STEP,
  parameter int HYST     = DEFAULT_HYST,
  parameter int DWELL    = 1000,
  parameter int AVG_LOG2 = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  fan_speed_ctrl_if.slave bus
);

  localparam int DW = clog2(DWELL + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL);

  logic [1:0]    state;
  logic [DW-1:0] dwell_cnt;
  logic [LW-1:0] giro;
  logic          giro_chg;
  logic [W-1:0]  diferencia;

  logic          accept;
  logic          restart;
  logic          win_done;
  logic [W-1:0]  avg;
  logic [W-1:0]  dif_next;
  logic [LW-1:0] up_lvl;
  logic [LW-1:0] down_lvl;
  logic [LW-1:0] target;

  // Smallest k >= 1 with d <= k*STEP, clamped to the top level. Scanning
  // downward lets the smallest matching threshold win without a divider.
  function automatic logic [LW-1:0] lvl(input logic [W-1:0] d);
    logic [LW-1:0] r;
    r = LW'(LEVELS - 1);
    for (int k = LEVELS - 2; k >= 1; k--) begin
      if (int'(d) <= k * STEP) r = LW'(k);
    end
    if (d == '0) r = '0;
    return r;
  endfunction

  function automatic logic [W-1:0] add_hyst(input logic [W-1:0] d);
    logic [W:0] s;
    s = {1'b0, d} + (W + 1)'(HYST);
    return s[W] ? '1 : s[W-1:0];
  endfunction

  assign accept  = bus.enable && bus.adc_valid && (state != ST_IDLE);
  assign restart = bus.enable && (state == ST_EVAL);

  sample_avg #(
    .W        (W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_sample_avg (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!bus.enable),
    .restart (restart),
    .accept  (accept),
    .sample  (bus.adc),
    .avg     (avg),
    .done    (win_done)
  );

  // Excess and single-step target for the window being evaluated. Going up
  // uses the raw excess; going down needs the excess to clear the hysteresis.
  always_comb begin
    dif_next = (avg > bus.teclado) ? avg - bus.teclado : '0;
    up_lvl   = lvl(dif_next);
    down_lvl = (dif_next == '0) ? '0 : lvl(add_hyst(dif_next));
    target   = giro;
    if (up_lvl > giro) begin
      target = giro + 1'b1;
    end else if (down_lvl < giro) begin
      target = giro - 1'b1;
    end
  end

  // Window sequencing; dropping enable wins over everything, including EVAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (!bus.enable) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state <= ST_ACCUM;
        ST_ACCUM: if (win_done) state <= ST_EVAL;
        ST_EVAL:  state <= ST_ACCUM;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Level register and dwell timer. The timer saturates at DWELL so a change
  // is allowed as soon as it is due; a blocked request is simply dropped and
  // reconsidered at the next evaluation. Forcing off bypasses the dwell and
  // re-arms it so the first change after re-enable is immediate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      giro       <= '0;
      giro_chg   <= 1'b0;
      diferencia <= '0;
      dwell_cnt  <= DWELL_MAX;
    end else begin
      giro_chg <= 1'b0;
      if (!bus.enable) begin
        giro      <= '0;
        giro_chg  <= (giro != '0);
        dwell_cnt <= DWELL_MAX;
      end else if (state == ST_EVAL && target != giro && dwell_cnt == DWELL_MAX) begin
        diferencia <= dif_next;
        giro       <= target;
        giro_chg   <= 1'b1;
        dwell_cnt  <= '0;
      end else begin
        if (state == ST_EVAL) diferencia <= dif_next;
        if (dwell_cnt != DWELL_MAX) dwell_cnt <= dwell_cnt + 1'b1;
      end
    end
  end

  assign bus.giro       = giro;
  assign bus.giro_chg   = giro_chg;
  assign bus.diferencia = diferencia;

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// tb_fan_speed_ctrl: self-checking bench for fan_speed_ctrl with a small
// behavioural model of level selection and dwell, feeding a scoreboard queue.
module tb_fan_speed_ctrl;

  localparam int W        = 8;
  localparam int LEVELS   = 4;
  localparam int LW       = 2;
  localparam int STEP     = 20;
  localparam int HYST     = 2;
  localparam int DWELL    = 8;
  localparam int AVG_LOG2 = 2;

  typedef struct {
    logic [W-1:0]  dif;
    logic [LW-1:0] giro;
    logic          chg;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   compared   = 0;
  int   mismatched = 0;
  int   m_giro     = 0;
  int   m_last_chg = -1000;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Edge index, so the model knows when each evaluation edge happens.
  always @(posedge clk) cyc <= cyc + 1;

  fan_speed_ctrl_if #(.W(W), .LW(LW)) bus ();

  fan_speed_ctrl #(
    .W        (W),
    .LEVELS   (LEVELS),
    .LW       (LW),
    .STEP     (STEP),
    .HYST     (HYST),
    .DWELL    (DWELL),
    .AVG_LOG2 (AVG_LOG2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic int model_lvl(input int d);
    int k;
    if (d == 0) return 0;
    k = (d + STEP - 1) / STEP;
    if (k > LEVELS - 1) k = LEVELS - 1;
    return k;
  endfunction

  // Called right after the last sample edge; the evaluation edge is the next one.
  task automatic push_expect(input int avg, input int tec);
    exp_t e;
    int dif, up, down, req, hd, eval_edge;
    eval_edge = cyc + 1;
    dif  = (avg > tec) ? avg - tec : 0;
    hd   = (dif + HYST > 255) ? 255 : dif + HYST;
    up   = model_lvl(dif);
    down = (dif == 0) ? 0 : model_lvl(hd);
    req  = m_giro;
    if (up > m_giro) req = m_giro + 1;
    else if (down < m_giro) req = m_giro - 1;
    e.chg = 1'b0;
    if (req != m_giro && (eval_edge - m_last_chg) >= DWELL + 1) begin
      m_giro     = req;
      m_last_chg = eval_edge;
      e.chg      = 1'b1;
    end
    e.dif  = W'(dif);
    e.giro = LW'(m_giro);
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [W-1:0] s0, input logic [W-1:0] s1,
                               input logic [W-1:0] s2, input logic [W-1:0] s3,
                               input logic [W-1:0] tec, input int gap);
    bus.teclado   = tec;
    bus.adc_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.adc_valid = 1'b1;
    bus.adc = s0; @(negedge clk);
    bus.adc = s1; @(negedge clk);
    bus.adc = s2; @(negedge clk);
    bus.adc = s3; @(negedge clk);
    bus.adc_valid = 1'b0;
    push_expect((int'(s0) + int'(s1) + int'(s2) + int'(s3)) / 4, int'(tec));
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.enable = 1'b0; bus.adc_valid = 1'b0; bus.adc = '0; bus.teclado = '0;
    repeat (3) @(negedge clk);
    compared++;
    if (bus.giro !== 2'd0 || bus.giro_chg !== 1'b0 || bus.diferencia !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_values: got giro=%0d chg=%0b dif=%0d, want 0 0 0",
               bus.giro, bus.giro_chg, bus.diferencia);
    end
    rst_n = 1'b1;
    bus.enable = 1'b1;
    m_giro = 0; m_last_chg = -1000;
  endtask

  // Runs windows of four samples each and checks the result edge and the
  // following cycle (pulse must last exactly one cycle).
  task automatic test_windows(input string name, input logic [W-1:0] s0,
                              input logic [W-1:0] s1, input logic [W-1:0] s2,
                              input logic [W-1:0] s3, input logic [W-1:0] tec,
                              input int count);
    exp_t e;
    for (int w = 0; w < count; w++) begin
      compared++;
      if (bus.giro_chg !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL %s_idle_chg[%0d]: got chg=%0b, want 0", name, w, bus.giro_chg);
      end
      applyStimulus(s0, s1, s2, s3, tec, 10);
      @(negedge clk);
      e = sb.pop_front();
      compared++;
      if (bus.diferencia !== e.dif || bus.giro !== e.giro || bus.giro_chg !== e.chg) begin
        mismatched++;
        $display("[TB] FAIL %s[%0d]: got dif=%0d giro=%0d chg=%0b, want dif=%0d giro=%0d chg=%0b",
                 name, w, bus.diferencia, bus.giro, bus.giro_chg, e.dif, e.giro, e.chg);
      end
      @(negedge clk);
      compared++;
      if (bus.giro_chg !== 1'b0 || bus.giro !== e.giro) begin
        mismatched++;
        $display("[TB] FAIL %s_after[%0d]: got giro=%0d chg=%0b, want giro=%0d chg=0",
                 name, w, bus.giro, bus.giro_chg, e.giro);
      end
    end
  endtask

  task automatic test_below_setpoint;
    test_windows("below_setpoint", 8'd10, 8'd10, 8'd10, 8'd10, 8'd30, 1);
  endtask

  task automatic test_basic;
    test_windows("basic", 8'd50, 8'd50, 8'd50, 8'd50, 8'd25, 2);
  endtask

  task automatic test_hysteresis;
    // avg 49 -> excess 19 holds level 2; avg 48 (truncated) -> 18 drops to 1
    test_windows("hyst_hold", 8'd49, 8'd49, 8'd50, 8'd50, 8'd30, 1);
    test_windows("hyst_drop", 8'd48, 8'd49, 8'd49, 8'd49, 8'd30, 1);
  endtask

  task automatic test_enable_drop(input int partial);
    logic exp_chg;
    for (int i = 0; i < partial; i++) begin
      bus.adc_valid = 1'b1; bus.adc = 8'd255;
      @(negedge clk);
    end
    bus.adc_valid = 1'b0;
    bus.enable    = 1'b0;
    exp_chg       = (m_giro != 0);
    m_giro = 0; m_last_chg = -1000;
    @(negedge clk);
    compared++;
    if (bus.giro !== 2'd0 || bus.giro_chg !== exp_chg) begin
      mismatched++;
      $display("[TB] FAIL enable_drop: got giro=%0d chg=%0b, want giro=0 chg=%0b",
               bus.giro, bus.giro_chg, exp_chg);
    end
    @(negedge clk);
    compared++;
    if (bus.giro_chg !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL enable_drop_pulse: got chg=%0b, want 0", bus.giro_chg);
    end
    // A valid sample during the IDLE->ACCUM cycle must be ignored.
    bus.enable = 1'b1; bus.adc_valid = 1'b1; bus.adc = 8'd255;
    @(negedge clk);
    bus.adc_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    bus.teclado = 8'd25;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.adc_valid = 1'b1; bus.adc = 8'd50;
      @(negedge clk);
      if (i == 3 || i == 7) push_expect(50, 25);
      if (i == 4) begin
        e = sb.pop_front();
        compared++;
        if (bus.diferencia !== e.dif || bus.giro !== e.giro || bus.giro_chg !== e.chg) begin
          mismatched++;
          $display("[TB] FAIL b2b_first: got dif=%0d giro=%0d chg=%0b, want dif=%0d giro=%0d chg=%0b",
                   bus.diferencia, bus.giro, bus.giro_chg, e.dif, e.giro, e.chg);
        end
      end
    end
    bus.adc_valid = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    compared++;
    if (bus.diferencia !== e.dif || bus.giro !== e.giro || bus.giro_chg !== e.chg) begin
      mismatched++;
      $display("[TB] FAIL b2b_blocked: got dif=%0d giro=%0d chg=%0b, want dif=%0d giro=%0d chg=%0b",
               bus.diferencia, bus.giro, bus.giro_chg, e.dif, e.giro, e.chg);
    end
    test_windows("b2b_third", 8'd50, 8'd50, 8'd50, 8'd50, 8'd25, 1);
  endtask

  task automatic test_saturation;
    test_windows("saturation", 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 4);
  endtask

  task automatic test_reset_mid_window;
    test_windows("pre_reset", 8'd40, 8'd40, 8'd40, 8'd40, 8'd25, 1);
    bus.teclado = 8'd25;
    repeat (2) @(negedge clk);
    bus.adc_valid = 1'b1; bus.adc = 8'd200;
    repeat (2) @(negedge clk);
    bus.adc_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    compared++;
    if (bus.giro !== 2'd0 || bus.diferencia !== 8'd0 || bus.giro_chg !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got giro=%0d dif=%0d chg=%0b, want 0 0 0",
               bus.giro, bus.diferencia, bus.giro_chg);
    end
    #1;
    rst_n = 1'b1;
    m_giro = 0; m_last_chg = -1000;
    test_windows("post_reset", 8'd40, 8'd40, 8'd40, 8'd40, 8'd25, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_below_setpoint();
    test_basic();
    test_hysteresis();
    test_enable_drop(0);
    test_back_to_back();
    test_enable_drop(0);
    test_saturation();
    test_enable_drop(2);
    test_reset_mid_window();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
